obstacle_scroller: RTL and testbench
====================================

Name: obstacle_scroller

Overview:
- Produces the obstacle coordinates consumed by the crash checker: mountain1, mountain2 and lava.
- Scrolls each obstacle leftward toward the fixed-x plane once per frame tick.
- Respawns an obstacle at the right edge with a pseudo-random height when it exits.
- Runs the IDLE/RUN/OVER game-flow FSM, freezes on game_over, and keeps a score with a score-driven speed level.

Parameters:
- X_SPAWN, 320: x loaded on respawn.
- GAP, 160: initial x offset of mountain2 from mountain1. Lava starts at X_SPAWN+GAP/2.
- MTN_Y_MIN, 160: minimum mountain top y. Mountain y = MTN_Y_MIN + 6-bit random.
- LAVA_Y_MIN, 40: minimum lava y. Lava y = LAVA_Y_MIN + 7-bit random.
- MAX_SPEED, 6: speed-level cap, in pixels per frame.
- LFSR_SEED, 10'h2A5: LFSR reset value. Must be nonzero.

Ports:
- clk, in, 1: system clock.
- resetn, in, 1: asynchronous, active-low reset.
- frame_tick, in, 1: one-cycle pulse per video frame.
- start, in, 1: level/pulse request to begin a game.
- game_over, in, 1: crash/reset indication from the crash checker.
- mountain1_x / mountain1_y, out, 10 each: mountain1 position.
- mountain2_x / mountain2_y, out, 10 each: mountain2 position.
- lava_x / lava_y, out, 10 each: lava position.
- score, out, 8: obstacles cleared, saturating.
- speed, out, 3: current pixels moved per frame_tick.
- running, out, 1: high in RUN only.

Behaviour:
- Clocking and reset:
  - All state updates on the clk rising edge.
  - resetn low asynchronously forces: state IDLE; all six coordinates 10'h3FF (parked off-screen); score 0; speed 1; running 0; LFSR = LFSR_SEED.
- LFSR:
  - 10-bit Fibonacci, polynomial x^10+x^7+1.
  - Shifts every clock in every state, including IDLE, so the start time seeds the randomness.
  - Next bit = lfsr[9]^lfsr[6], shifted into bit 0.
- Random slices, all taken from the current (pre-shift) LFSR value:
  - mountain1: lfsr[5:0].
  - mountain2: lfsr[9:4].
  - lava: lfsr[6:0].
- IDLE:
  - Outputs stay parked; frame_tick and game_over are ignored.
  - start=1 loads the initial game on the next edge and enters RUN:
    - mountain1_x=X_SPAWN; mountain2_x=X_SPAWN+GAP; lava_x=X_SPAWN+GAP/2.
    - Each y = its minimum + its slice.
    - score=0; speed=1.
  - No movement occurs in the load cycle, even if frame_tick=1.
- RUN:
  - game_over=1 enters OVER next edge. Priority: game_over beats frame_tick, so nothing moves that cycle. start is ignored in RUN.
  - Otherwise, on frame_tick, each obstacle independently:
    - If x <= speed (unsigned 10-bit compare): x <= X_SPAWN and y <= new random value. This is a respawn.
    - Else: x <= x - speed, y unchanged.
  - Subtraction never underflows.
- Score and speed:
  - score += number of obstacles respawned that tick (0..3), saturating at 255.
  - speed is combinationally recomputed from the updated score and registered in the same edge: min(1 + score[7:3], MAX_SPEED).
  - The new speed applies from the next frame_tick.
- OVER:
  - All coordinates, score and speed frozen; running=0.
  - start=1 performs the same load as in IDLE and enters RUN. score is reset to 0 in that same edge.
  - game_over held high concurrently with start:
    - The load still happens.
    - RUN sees game_over on the following edge and returns to OVER. This is intended: the crash checker drives game_over high while resetn is low.
- Width rules:
  - All coordinate arithmetic is 10-bit unsigned. Parameter sums must be < 1024; this is checked with a simulation assertion.
  - speed is zero-extended to 10 bits for compare and subtract.
- Latency:
  - Outputs change exactly one edge after the qualifying frame_tick or start.
  - running reflects the state register directly, with no extra delay.

Test Plan:
- Reset, then idle 10 cycles with frame_tick pulsing -> all coords 10'h3FF, score 0, speed 1, running 0.
- Start, then 5 frame_ticks -> mountain1_x 320→315, mountain2_x 480→475, lava_x 400→395. Each y within its range and unchanged. running=1.
- Force mountain1_x=1 (drive to respawn, speed 1) -> next tick mountain1_x=320, y = 160+lfsr[5:0] from that cycle, score +1. Then let mountain1 and lava respawn on the same tick -> score +2.
- Run until score reaches 8, then 40 -> speed 2 then 6; score 48 -> speed stays 6 (cap). Score driven past 255 -> stays 255.
- game_over asserted in the same cycle as frame_tick -> state OVER, no coordinate change, running=0. Further ticks -> frozen. start -> initial positions reloaded, score 0, RUN.
- Assert resetn low mid-RUN, between edges -> outputs immediately parked/zeroed. Release resetn -> IDLE, and the LFSR restarts at 10'h2A5 (check the first respawn y against the expected sequence).

Source files
------------

// File: rtl/obstacle_scroller.sv
// obstacle_scroller
//   Produces the mountain1 / mountain2 / lava coordinates consumed by the
//   crash checker. Each obstacle scrolls left by `speed` pixels per
//   frame_tick and respawns at the right edge with a pseudo-random height
//   once it reaches the fixed-x plane. An IDLE/RUN/OVER game-flow FSM gates
//   the movement, freezes everything on game_over, and a saturating score
//   drives the speed level.
//
// Ports
//   clk          in   system clock
//   resetn       in   asynchronous active-low reset
//   frame_tick   in   one-cycle pulse per video frame
//   start        in   request to begin a game (level or pulse)
//   game_over    in   crash indication from the crash checker
//   mountain1_x/_y, mountain2_x/_y, lava_x/_y   out [9:0] obstacle positions
//   score        out [7:0] obstacles cleared, saturating at 255
//   speed        out [2:0] pixels moved per frame_tick
//   running      out       high while in RUN
module obstacle_scroller #(
  parameter int unsigned X_SPAWN    = 320,
  parameter int unsigned GAP        = 160,
  parameter int unsigned MTN_Y_MIN  = 160,
  parameter int unsigned LAVA_Y_MIN = 40,
  parameter int unsigned MAX_SPEED  = 6,
  parameter logic [9:0]  LFSR_SEED  = 10'h2A5
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       game_over,
  output logic [9:0] mountain1_x,
  output logic [9:0] mountain1_y,
  output logic [9:0] mountain2_x,
  output logic [9:0] mountain2_y,
  output logic [9:0] lava_x,
  output logic [9:0] lava_y,
  output logic [7:0] score,
  output logic [2:0] speed,
  output logic       running
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam logic [9:0] PARKED     = '1;
  localparam logic [9:0] X_RESPAWN  = 10'(X_SPAWN);
  localparam logic [9:0] X_M1_INIT  = 10'(X_SPAWN);
  localparam logic [9:0] X_M2_INIT  = 10'(X_SPAWN + GAP);
  localparam logic [9:0] X_LV_INIT  = 10'(X_SPAWN + GAP / 2);
  localparam logic [9:0] MTN_Y0     = 10'(MTN_Y_MIN);
  localparam logic [9:0] LAVA_Y0    = 10'(LAVA_Y_MIN);
  localparam logic [5:0] SPEED_CAP  = 6'(MAX_SPEED);

  // Every coordinate sum must fit in 10 bits; the seed must be nonzero or
  // the LFSR locks up; the speed cap must fit the 3-bit speed output.
  localparam bit PARAMS_OK = (X_SPAWN + GAP < 1024)
                          && (MTN_Y_MIN + 63 < 1024)
                          && (LAVA_Y_MIN + 127 < 1024)
                          && (LFSR_SEED != '0)
                          && (MAX_SPEED >= 1) && (MAX_SPEED <= 7);

  state_t     state_q, state_d;
  logic [9:0] lfsr_q, lfsr_d;
  logic [9:0] m1_x_q, m1_x_d, m1_y_q, m1_y_d;
  logic [9:0] m2_x_q, m2_x_d, m2_y_q, m2_y_d;
  logic [9:0] lv_x_q, lv_x_d, lv_y_q, lv_y_d;
  logic [7:0] score_q, score_d;
  logic [2:0] speed_q, speed_d;

  // Random heights, all taken from the pre-shift LFSR value
  logic [9:0] rnd_m1_y, rnd_m2_y, rnd_lv_y;

  // Per-obstacle scroll step results
  logic [9:0] speed_ext;
  logic       hit_m1, hit_m2, hit_lv;
  logic [9:0] m1_x_step, m2_x_step, lv_x_step;
  logic [9:0] m1_y_step, m2_y_step, lv_y_step;
  logic [1:0] n_hits;
  logic [8:0] score_sum;
  logic [7:0] score_step;
  logic [5:0] level;
  logic [2:0] speed_step;

  // Fibonacci LFSR, x^10 + x^7 + 1, free-running in every state
  always_comb begin
    lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
  end

  always_comb begin
    rnd_m1_y = MTN_Y0  + {4'b0, lfsr_q[5:0]};
    rnd_m2_y = MTN_Y0  + {4'b0, lfsr_q[9:4]};
    rnd_lv_y = LAVA_Y0 + {3'b0, lfsr_q[6:0]};
  end

  // One frame of scrolling. Respawn when x <= speed, so the subtraction
  // below is only ever taken with x > speed and cannot underflow.
  always_comb begin
    speed_ext = {7'b0, speed_q};
    hit_m1    = (m1_x_q <= speed_ext);
    hit_m2    = (m2_x_q <= speed_ext);
    hit_lv    = (lv_x_q <= speed_ext);

    m1_x_step = hit_m1 ? X_RESPAWN : (m1_x_q - speed_ext);
    m2_x_step = hit_m2 ? X_RESPAWN : (m2_x_q - speed_ext);
    lv_x_step = hit_lv ? X_RESPAWN : (lv_x_q - speed_ext);
    m1_y_step = hit_m1 ? rnd_m1_y : m1_y_q;
    m2_y_step = hit_m2 ? rnd_m2_y : m2_y_q;
    lv_y_step = hit_lv ? rnd_lv_y : lv_y_q;

    n_hits     = {1'b0, hit_m1} + {1'b0, hit_m2} + {1'b0, hit_lv};
    score_sum  = {1'b0, score_q} + {7'b0, n_hits};
    score_step = score_sum[8] ? 8'hFF : score_sum[7:0];

    // Speed level follows the updated score in the same edge
    level      = 6'd1 + {1'b0, score_step[7:3]};
    speed_step = (level > SPEED_CAP) ? SPEED_CAP[2:0] : level[2:0];
  end

  // Next-state / datapath selection
  always_comb begin
    state_d = state_q;
    m1_x_d  = m1_x_q;
    m1_y_d  = m1_y_q;
    m2_x_d  = m2_x_q;
    m2_y_d  = m2_y_q;
    lv_x_d  = lv_x_q;
    lv_y_d  = lv_y_q;
    score_d = score_q;
    speed_d = speed_q;

    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        // Load a fresh game; frame_tick is deliberately not applied here
        if (start) begin
          state_d = ST_RUN;
          m1_x_d  = X_M1_INIT;
          m2_x_d  = X_M2_INIT;
          lv_x_d  = X_LV_INIT;
          m1_y_d  = rnd_m1_y;
          m2_y_d  = rnd_m2_y;
          lv_y_d  = rnd_lv_y;
          score_d = '0;
          speed_d = 3'd1;
        end
      end
      ST_RUN: begin
        // game_over wins over frame_tick: freeze without moving
        if (game_over) begin
          state_d = ST_OVER;
        end else if (frame_tick) begin
          m1_x_d  = m1_x_step;
          m2_x_d  = m2_x_step;
          lv_x_d  = lv_x_step;
          m1_y_d  = m1_y_step;
          m2_y_d  = m2_y_step;
          lv_y_d  = lv_y_step;
          score_d = score_step;
          speed_d = speed_step;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      lfsr_q  <= LFSR_SEED;
      m1_x_q  <= PARKED;
      m1_y_q  <= PARKED;
      m2_x_q  <= PARKED;
      m2_y_q  <= PARKED;
      lv_x_q  <= PARKED;
      lv_y_q  <= PARKED;
      score_q <= '0;
      speed_q <= 3'd1;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      m1_x_q  <= m1_x_d;
      m1_y_q  <= m1_y_d;
      m2_x_q  <= m2_x_d;
      m2_y_q  <= m2_y_d;
      lv_x_q  <= lv_x_d;
      lv_y_q  <= lv_y_d;
      score_q <= score_d;
      speed_q <= speed_d;
    end
  end

  always_ff @(posedge clk) begin
    assert (PARAMS_OK)
      else $error("obstacle_scroller: parameter set overflows 10-bit coordinates or is invalid");
  end

  assign mountain1_x = m1_x_q;
  assign mountain1_y = m1_y_q;
  assign mountain2_x = m2_x_q;
  assign mountain2_y = m2_y_q;
  assign lava_x      = lv_x_q;
  assign lava_y      = lv_y_q;
  assign score       = score_q;
  assign speed       = speed_q;
  assign running     = (state_q == ST_RUN);

endmodule

// File: tb/tb_obstacle_scroller.sv
// Self-checking bench for obstacle_scroller. A behavioural game model
// (integer arithmetic over arrays) is stepped once per clock edge and every
// DUT output is compared against it after each edge, alongside directed
// constant checks for the scenarios of interest.
module tb_obstacle_scroller;

  logic       clk = 1'b0;
  logic       resetn;
  logic       frame_tick;
  logic       start;
  logic       game_over;
  logic [9:0] mountain1_x, mountain1_y;
  logic [9:0] mountain2_x, mountain2_y;
  logic [9:0] lava_x, lava_y;
  logic [7:0] score;
  logic [2:0] speed;
  logic       running;

  int passes = 0;
  int fails  = 0;
  int checks = 0;

  // Behavioural model: 0 = idle, 1 = run, 2 = over
  int          m_state;
  int          m_x[3];
  int          m_y[3];
  int          m_score;
  int          m_speed;
  int unsigned m_lfsr;

  obstacle_scroller #(
    .X_SPAWN    (320),
    .GAP        (160),
    .MTN_Y_MIN  (160),
    .LAVA_Y_MIN (40),
    .MAX_SPEED  (6),
    .LFSR_SEED  (10'h2A5)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .frame_tick  (frame_tick),
    .start       (start),
    .game_over   (game_over),
    .mountain1_x (mountain1_x),
    .mountain1_y (mountain1_y),
    .mountain2_x (mountain2_x),
    .mountain2_y (mountain2_y),
    .lava_x      (lava_x),
    .lava_y      (lava_y),
    .score       (score),
    .speed       (speed),
    .running     (running)
  );

  always #5 clk = ~clk;

  function automatic int rand_y(int k, int unsigned l);
    case (k)
      0:       return 160 + int'(l % 64);
      1:       return 160 + int'((l / 16) % 64);
      default: return 40 + int'(l % 128);
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0;
    for (int i = 0; i < 3; i++) begin
      m_x[i] = 1023;
      m_y[i] = 1023;
    end
    m_score = 0;
    m_speed = 1;
    m_lfsr  = 'h2A5;
  endtask

  task automatic model_load();
    m_x[0] = 320;
    m_x[1] = 480;
    m_x[2] = 400;
    for (int i = 0; i < 3; i++) m_y[i] = rand_y(i, m_lfsr);
    m_score = 0;
    m_speed = 1;
    m_state = 1;
  endtask

  task automatic model_edge(bit ft, bit st, bit go);
    case (m_state)
      1: begin
        if (go) begin
          m_state = 2;
        end else if (ft) begin
          int n = 0;
          for (int i = 0; i < 3; i++) begin
            if (m_x[i] <= m_speed) begin
              m_x[i] = 320;
              m_y[i] = rand_y(i, m_lfsr);
              n++;
            end else begin
              m_x[i] = m_x[i] - m_speed;
            end
          end
          m_score = (m_score + n > 255) ? 255 : m_score + n;
          m_speed = 1 + m_score / 8;
          if (m_speed > 6) m_speed = 6;
        end
      end
      default: if (st) model_load();
    endcase
    m_lfsr = ((m_lfsr * 2) % 1024) | (((m_lfsr / 512) ^ (m_lfsr / 64)) & 1);
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".m1x"},   32'(mountain1_x), 32'(m_x[0]));
    chk({tag, ".m1y"},   32'(mountain1_y), 32'(m_y[0]));
    chk({tag, ".m2x"},   32'(mountain2_x), 32'(m_x[1]));
    chk({tag, ".m2y"},   32'(mountain2_y), 32'(m_y[1]));
    chk({tag, ".lvx"},   32'(lava_x),      32'(m_x[2]));
    chk({tag, ".lvy"},   32'(lava_y),      32'(m_y[2]));
    chk({tag, ".score"}, 32'(score),       32'(m_score));
    chk({tag, ".speed"}, 32'(speed),       32'(m_speed));
    chk({tag, ".run"},   32'(running),     32'(m_state == 1));
  endtask

  task automatic cycle(bit ft, bit st, bit go);
    frame_tick = ft;
    start      = st;
    game_over  = go;
    model_edge(ft, st, go);
    @(posedge clk);
    #1;
    check_all("cyc");
  endtask

  task automatic rand_run_cycle();
    cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 1'b0);
  endtask

  initial begin
    logic [9:0] sy0, sy1, sy2;
    logic [9:0] sx0, sx1, sx2;
    int prev_score;
    int guard;

    resetn     = 1'b0;
    frame_tick = 1'b0;
    start      = 1'b0;
    game_over  = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    chk("reset_m1x", 32'(mountain1_x), 32'h3FF);
    chk("reset_speed", 32'(speed), 32'd1);
    @(negedge clk);
    resetn = 1'b1;

    // Idle: ticks and game_over ignored
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    chk("idle_lvx", 32'(lava_x), 32'h3FF);
    chk("idle_run", 32'(running), 32'd0);

    // Start with frame_tick high: load only, no movement
    cycle(1'b1, 1'b1, 1'b0);
    chk("load_m1x", 32'(mountain1_x), 32'd320);
    chk("load_m2x", 32'(mountain2_x), 32'd480);
    chk("load_lvx", 32'(lava_x), 32'd400);
    chk("load_run", 32'(running), 32'd1);
    chk("m1y_range", 32'(mountain1_y >= 160 && mountain1_y <= 223), 32'd1);
    chk("m2y_range", 32'(mountain2_y >= 160 && mountain2_y <= 223), 32'd1);
    chk("lvy_range", 32'(lava_y >= 40 && lava_y <= 167), 32'd1);
    sy0 = mountain1_y;
    sy1 = mountain2_y;
    sy2 = lava_y;
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0);
    chk("t5_m1x", 32'(mountain1_x), 32'd315);
    chk("t5_m2x", 32'(mountain2_x), 32'd475);
    chk("t5_lvx", 32'(lava_x), 32'd395);
    chk("t5_m1y", 32'(mountain1_y), 32'(sy0));
    chk("t5_m2y", 32'(mountain2_y), 32'(sy1));
    chk("t5_lvy", 32'(lava_y), 32'(sy2));

    // Scroll mountain1 down to x=1, then the respawn tick
    guard = 0;
    while (m_x[0] != 1 && guard < 400) begin
      cycle(1'b1, 1'b0, 1'b0);
      guard++;
    end
    chk("reach_m1_x1", 32'(mountain1_x), 32'd1);
    prev_score = m_score;
    cycle(1'b1, 1'b0, 1'b0);
    chk("respawn_m1x", 32'(mountain1_x), 32'd320);
    chk("respawn_score", 32'(score), 32'(prev_score + 1));

    // Randomized play up through the speed levels
    guard = 0;
    while (m_score < 8 && guard < 20000) begin rand_run_cycle(); guard++; end
    chk("score8_reached", 32'(m_score >= 8), 32'd1);
    chk("speed_at_8", 32'(speed), 32'd2);
    guard = 0;
    while (m_score < 40 && guard < 20000) begin rand_run_cycle(); guard++; end
    chk("score40_reached", 32'(m_score >= 40), 32'd1);
    chk("speed_at_40", 32'(speed), 32'd6);
    guard = 0;
    while (m_score < 48 && guard < 20000) begin rand_run_cycle(); guard++; end
    chk("speed_cap_48", 32'(speed), 32'd6);
    guard = 0;
    while (m_score < 255 && guard < 30000) begin rand_run_cycle(); guard++; end
    for (int i = 0; i < 150; i++) cycle(1'b1, 1'b0, 1'b0);
    chk("score_sat", 32'(score), 32'd255);
    chk("speed_sat", 32'(speed), 32'd6);

    // game_over coincident with frame_tick: freeze without movement
    sx0 = mountain1_x;
    sx1 = mountain2_x;
    sx2 = lava_x;
    cycle(1'b1, 1'b0, 1'b1);
    chk("over_run", 32'(running), 32'd0);
    chk("over_m1x", 32'(mountain1_x), 32'(sx0));
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    chk("frozen_m2x", 32'(mountain2_x), 32'(sx1));
    chk("frozen_lvx", 32'(lava_x), 32'(sx2));
    chk("frozen_score", 32'(score), 32'd255);
    cycle(1'b1, 1'b1, 1'b0);
    chk("restart_m1x", 32'(mountain1_x), 32'd320);
    chk("restart_lvx", 32'(lava_x), 32'd400);
    chk("restart_score", 32'(score), 32'd0);
    chk("restart_speed", 32'(speed), 32'd1);
    chk("restart_run", 32'(running), 32'd1);
    for (int i = 0; i < 20; i++) rand_run_cycle();

    // start with game_over held: load, then straight back to OVER
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    chk("go_load_m2x", 32'(mountain2_x), 32'd480);
    chk("go_load_run", 32'(running), 32'd1);
    cycle(1'b1, 1'b0, 1'b1);
    chk("go_back_over", 32'(running), 32'd0);
    chk("go_no_move", 32'(mountain2_x), 32'd480);
    cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) rand_run_cycle();

    // Asynchronous reset between edges, mid-run
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    chk("async_m1y", 32'(mountain1_y), 32'h3FF);
    chk("async_run", 32'(running), 32'd0);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    // First edge after release loads from the seed value 10'h2A5
    cycle(1'b0, 1'b1, 1'b0);
    chk("seed_m1y", 32'(mountain1_y), 32'd197);
    chk("seed_m2y", 32'(mountain2_y), 32'd202);
    chk("seed_lvy", 32'(lava_y), 32'd77);
    for (int i = 0; i < 40; i++) rand_run_cycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
